// File: rtl/write_port.sv
// Write side of the 32 x 32-bit architectural register file: a valid/ready write
// port staged through a one-entry pending buffer that commits on the next unstalled edge.
module write_port (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        WR_VALID,
    input  logic [4:0]  WR_REG,
    input  logic [31:0] DATA_WRITE,
    input  logic        HOLD,
    output logic        WR_READY,
    output logic        PEND_VALID,
    output logic [4:0]  PEND_REG,
    output logic [31:0] PEND_DATA,
    output logic [15:0] WR_COUNT,
    output logic [31:0] Q0,
    output logic [31:0] Q1,
    output logic [31:0] Q2,
    output logic [31:0] Q3,
    output logic [31:0] Q4,
    output logic [31:0] Q5,
    output logic [31:0] Q6,
    output logic [31:0] Q7,
    output logic [31:0] Q8,
    output logic [31:0] Q9,
    output logic [31:0] Q10,
    output logic [31:0] Q11,
    output logic [31:0] Q12,
    output logic [31:0] Q13,
    output logic [31:0] Q14,
    output logic [31:0] Q15,
    output logic [31:0] Q16,
    output logic [31:0] Q17,
    output logic [31:0] Q18,
    output logic [31:0] Q19,
    output logic [31:0] Q20,
    output logic [31:0] Q21,
    output logic [31:0] Q22,
    output logic [31:0] Q23,
    output logic [31:0] Q24,
    output logic [31:0] Q25,
    output logic [31:0] Q26,
    output logic [31:0] Q27,
    output logic [31:0] Q28,
    output logic [31:0] Q29,
    output logic [31:0] Q30,
    output logic [31:0] Q31
);

    // Register 0 is hardwired to zero, so only 1..31 are stored.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic        pend_valid_q, pend_valid_d;
    logic [4:0]  pend_reg_q,   pend_reg_d;
    logic [31:0] pend_data_q,  pend_data_d;
    logic [15:0] wr_count_q,   wr_count_d;

    logic        accept;
    logic        commit;
    logic [31:1] wr_sel;

    assign WR_READY = !pend_valid_q || !HOLD;
    assign accept   = WR_VALID && WR_READY;
    assign commit   = pend_valid_q && !HOLD;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_reg_d   = pend_reg_q;
        pend_data_d  = pend_data_q;
        wr_count_d   = wr_count_q;
        wr_sel       = '0;

        // An accept on a commit edge refills the buffer, so accept wins over clear.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_reg_d   = WR_REG;
            pend_data_d  = DATA_WRITE;
        end else if (commit) begin
            pend_valid_d = 1'b0;
        end

        for (int k = 1; k < 32; k++) begin
            wr_sel[k] = commit && (pend_reg_q == 5'(k));
        end

        if (|wr_sel) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        for (int k = 1; k < 32; k++) begin
            regs_d[k] = wr_sel[k] ? pend_data_q : regs_q[k];
        end
    end

    // NOTE: the register array is reset explicitly because architectural state must read zero after reset.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            pend_valid_q <= 1'b0;
            pend_reg_q   <= '0;
            pend_data_q  <= '0;
            wr_count_q   <= '0;
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_reg_q   <= pend_reg_d;
            pend_data_q  <= pend_data_d;
            wr_count_q   <= wr_count_d;
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    assign PEND_VALID = pend_valid_q;
    assign PEND_REG   = pend_reg_q;
    assign PEND_DATA  = pend_data_q;
    assign WR_COUNT   = wr_count_q;

    assign Q0  = '0;
    assign Q1  = regs_q[1];
    assign Q2  = regs_q[2];
    assign Q3  = regs_q[3];
    assign Q4  = regs_q[4];
    assign Q5  = regs_q[5];
    assign Q6  = regs_q[6];
    assign Q7  = regs_q[7];
    assign Q8  = regs_q[8];
    assign Q9  = regs_q[9];
    assign Q10 = regs_q[10];
    assign Q11 = regs_q[11];
    assign Q12 = regs_q[12];
    assign Q13 = regs_q[13];
    assign Q14 = regs_q[14];
    assign Q15 = regs_q[15];
    assign Q16 = regs_q[16];
    assign Q17 = regs_q[17];
    assign Q18 = regs_q[18];
    assign Q19 = regs_q[19];
    assign Q20 = regs_q[20];
    assign Q21 = regs_q[21];
    assign Q22 = regs_q[22];
    assign Q23 = regs_q[23];
    assign Q24 = regs_q[24];
    assign Q25 = regs_q[25];
    assign Q26 = regs_q[26];
    assign Q27 = regs_q[27];
    assign Q28 = regs_q[28];
    assign Q29 = regs_q[29];
    assign Q30 = regs_q[30];
    assign Q31 = regs_q[31];

endmodule

// File: tb/tb_write_port.sv
// Directed bench for write_port: handshake, pending buffer, stall, register 0,
// asynchronous reset and write-counter wrap, with hand-computed expectations.
module tb_write_port;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        WR_VALID;
    logic [4:0]  WR_REG;
    logic [31:0] DATA_WRITE;
    logic        HOLD;
    logic        WR_READY;
    logic        PEND_VALID;
    logic [4:0]  PEND_REG;
    logic [31:0] PEND_DATA;
    logic [15:0] WR_COUNT;
    logic [31:0] q [32];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    write_port dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .WR_VALID(WR_VALID), .WR_REG(WR_REG), .DATA_WRITE(DATA_WRITE), .HOLD(HOLD),
        .WR_READY(WR_READY), .PEND_VALID(PEND_VALID), .PEND_REG(PEND_REG),
        .PEND_DATA(PEND_DATA), .WR_COUNT(WR_COUNT),
        .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
        .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
        .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
        .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
        .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
        .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
        .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
        .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        WR_VALID   = v;
        WR_REG     = r;
        DATA_WRITE = d;
    endtask

    function automatic logic [31:0] q_or();
        logic [31:0] acc = '0;
        for (int i = 0; i < 32; i++) acc |= q[i];
        return acc;
    endfunction

    initial begin
        ctrl_reset_n = 1'b0;
        HOLD = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        #12;
        check("reset_ready",  {31'd0, WR_READY},   32'd1);
        check("reset_pend",   {31'd0, PEND_VALID}, 32'd0);
        check("reset_count",  {16'd0, WR_COUNT},   32'd0);
        check("reset_q_zero", q_or(),              32'd0);

        // Single write to r5, accepted on the first edge after release.
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("single_pend_v",   {31'd0, PEND_VALID}, 32'd1);
        check("single_pend_reg", {27'd0, PEND_REG},   32'd5);
        check("single_q5_early", q[5],                32'd0);
        tick();
        check("single_q5",       q[5],                32'hDEADBEEF);
        check("single_count",    {16'd0, WR_COUNT},   32'd1);
        check("single_pend_clr", {31'd0, PEND_VALID}, 32'd0);

        // Back-to-back r1 then r2.
        drive(1'b1, 5'd1, 32'h11);
        tick();
        check("b2b_ready1", {31'd0, WR_READY}, 32'd1);
        drive(1'b1, 5'd2, 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("b2b_q1",     q[1],                32'h11);
        check("b2b_pend_v", {31'd0, PEND_VALID}, 32'd1);
        check("b2b_ready2", {31'd0, WR_READY},   32'd1);
        tick();
        check("b2b_q2",     q[2],                32'h22);
        check("b2b_count",  {16'd0, WR_COUNT},   32'd3);

        // Stall r7 for three cycles while r8 waits.
        drive(1'b1, 5'd7, 32'h77);
        tick();
        HOLD = 1'b1;
        drive(1'b1, 5'd8, 32'h88);
        #1;
        check("stall_ready0", {31'd0, WR_READY}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_q7",    q[7],               32'd0);
            check("stall_preg",  {27'd0, PEND_REG},  32'd7);
            check("stall_pdata", PEND_DATA,          32'h77);
            check("stall_ready", {31'd0, WR_READY},  32'd0);
        end
        HOLD = 1'b0;
        #1;
        check("release_ready", {31'd0, WR_READY}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("release_q7",    q[7],              32'h77);
        check("release_preg",  {27'd0, PEND_REG}, 32'd8);
        check("release_pdata", PEND_DATA,         32'h88);
        check("release_q8_0",  q[8],              32'd0);
        tick();
        check("release_q8",    q[8],              32'h88);
        check("release_count", {16'd0, WR_COUNT}, 32'd5);

        // HOLD with an empty buffer still accepts one request.
        HOLD = 1'b1;
        drive(1'b1, 5'd9, 32'h99);
        #1;
        check("hold_empty_ready", {31'd0, WR_READY}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("hold_empty_pend",  {31'd0, PEND_VALID}, 32'd1);
        check("hold_empty_preg",  {27'd0, PEND_REG},   32'd9);
        tick();
        check("hold_empty_q9_0",  q[9],                32'd0);
        HOLD = 1'b0;
        tick();
        check("hold_empty_q9",    q[9],                32'h99);
        check("hold_empty_count", {16'd0, WR_COUNT},   32'd6);

        // Register 0 write passes through the buffer but changes nothing.
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("r0_pend_set", {31'd0, PEND_VALID}, 32'd1);
        tick();
        check("r0_pend_clr", {31'd0, PEND_VALID}, 32'd0);
        check("r0_q0",       q[0],                32'd0);
        check("r0_q1_keep",  q[1],                32'h11);
        check("r0_count",    {16'd0, WR_COUNT},   32'd6);

        // Asynchronous reset with r3 pending, asserted between edges.
        drive(1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        check("rst_mid_pend", {31'd0, PEND_VALID}, 32'd1);
        #1;
        ctrl_reset_n = 1'b0;
        #1;
        check("rst_mid_pclr",  {31'd0, PEND_VALID}, 32'd0);
        check("rst_mid_q",     q_or(),              32'd0);
        check("rst_mid_count", {16'd0, WR_COUNT},   32'd0);
        check("rst_mid_ready", {31'd0, WR_READY},   32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        tick();
        tick();
        check("rst_after_q3",   q[3],                32'd0);
        check("rst_after_pend", {31'd0, PEND_VALID}, 32'd0);

        // 65536 accepts back-to-back leave 65535 commits and one pending.
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 5'd1, 32'(i));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0);
        check("wrap_pre_count", {16'd0, WR_COUNT},   32'h0000FFFF);
        check("wrap_pre_pend",  {31'd0, PEND_VALID}, 32'd1);
        tick();
        check("wrap_count",     {16'd0, WR_COUNT},   32'd0);
        check("wrap_q1",        q[1],                32'd65535);
        check("wrap_pend_clr",  {31'd0, PEND_VALID}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_port.md
# write_port

Write side of the processor register file. Owns the 32 × 32-bit architectural registers and drives their contents (Q0..Q31) to the existing read ports. Accepts write-back requests through a valid/ready handshake, stages them in a one-entry pending buffer, and commits each one on the next unstalled clock. The pending entry is exported so read-side logic can forward it.

## Interface
- No parameters. Widths are fixed: 32 registers, 32-bit data, 5-bit index.
- clock  input  1  sole clock; all state updates on the rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- WR_VALID  input  1  write request present.
- WR_REG  input  5  destination register index.
- DATA_WRITE  input  32  write data.
- HOLD  input  1  pipeline stall; blocks commit while high.
- WR_READY  output  1  request can be accepted this cycle (combinational).
- PEND_VALID  output  1  pending buffer holds an uncommitted write.
- PEND_REG  output  5  index of the pending write.
- PEND_DATA  output  32  data of the pending write.
- WR_COUNT  output  16  number of commits to registers 1..31.
- Q0..Q31  output  32 each  current register contents; Q0 is constant 0.

## Operation
- Handshake:
  - WR_READY = !PEND_VALID || !HOLD.
  - A request is accepted on an edge where WR_VALID && WR_READY.
  - WR_REG and DATA_WRITE are sampled only on acceptance.
- Pending buffer: an accepted request loads PEND_VALID=1, PEND_REG, and PEND_DATA.
- Commit: on any edge where PEND_VALID=1 and HOLD=0, PEND_DATA is written to register PEND_REG.
  - A one-hot 5-to-32 decode of PEND_REG selects the target register.
  - All other registers hold their values.
- Simultaneous commit and accept on the same edge: the commit happens and the buffer is overwritten with the new request, so PEND_VALID stays 1.
- Commit with no accept: PEND_VALID clears to 0.
- HOLD=1 with PEND_VALID=1:
  - No commit occurs; the buffer is unchanged.
  - WR_READY=0.
- HOLD=1 with PEND_VALID=0: one request may still be accepted into the buffer.
- Register 0:
  - A write to index 0 is accepted and passes through the buffer normally.
  - Its commit has no effect on any register, and WR_COUNT does not increment.
  - Q0 is always 0.
- WR_COUNT increments by 1 on each commit to index 1..31, and wraps from 0xFFFF to 0x0000.
- PEND_* outputs are raw register values. PEND_REG and PEND_DATA are don't-care when PEND_VALID=0, but hold their last loaded values.

## Timing
- Reset (ctrl_reset_n=0, asynchronous, takes effect immediately without a clock):
  - Q1..Q31 = 0, PEND_VALID = 0, PEND_REG = 0, PEND_DATA = 0, WR_COUNT = 0.
  - WR_READY = 1 whenever reset is asserted.
  - A write in the pending buffer when reset asserts is discarded and never commits.
- Deassertion of reset is sampled at the next rising edge. The first acceptance can occur on the first edge after deassertion.
- Latency with HOLD=0: the request is accepted at edge N, and Qk shows the new value after edge N+1.
- Throughput: one write per cycle while HOLD=0.
- Each cycle of HOLD on a pending entry delays its commit by one cycle.
- Q outputs change only at clock edges or on reset.
- WR_READY depends combinationally on HOLD and PEND_VALID only, never on WR_VALID.

## Test plan
- Reset → all Q = 0, WR_READY = 1, PEND_VALID = 0, WR_COUNT = 0.
- Single write: WR_REG=5, DATA_WRITE=0xDEADBEEF, HOLD=0, accepted at edge 1.
  - After edge 1: PEND_VALID=1, PEND_REG=5, Q5=0.
  - After edge 2: Q5=0xDEADBEEF, WR_COUNT=1, PEND_VALID=0.
- Back-to-back writes: reg1=0x11 then reg2=0x22 on consecutive cycles, HOLD=0.
  - After edge 2: Q1=0x11.
  - After edge 3: Q2=0x22, WR_COUNT=2.
  - WR_READY stays 1 throughout.
- Stall: pending reg7=0x77 and HOLD=1 for 3 cycles.
  - During the stall: WR_READY=0, Q7 unchanged, a new request on reg8 is not accepted.
  - Release HOLD: Q7=0x77 after the next edge, and reg8 is accepted on that same edge.
- Register 0: write 0xFFFFFFFF to index 0 → Q0 stays 0, WR_COUNT unchanged, PEND_VALID goes 1 then 0.
- Reset mid-operation: pending reg3=0x33, then drop ctrl_reset_n between edges.
  - Immediately: PEND_VALID=0 and all Q = 0.
  - After release: Q3 stays 0.
- Wrap: preload WR_COUNT to 0xFFFF with 65535 commits, then one more commit → WR_COUNT=0x0000.
